// File: rtl/if_stage_fq.sv
// Decoupled instruction-fetch stage.
// Issues one request per cycle to a 1-cycle synchronous instruction memory.
// Returned words are buffered with their PC in a circular fetch queue that
// feeds decode over a valid/ready handshake. A redirect from execute flushes
// the queue and drops any in-flight response.
module if_stage_fq #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned      INSTR_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       Reset,
    output logic                       imem_req,
    output logic [WIDTH-1:0]           imem_addr,
    input  logic [WIDTH-1:0]           imem_rdata,
    input  logic                       Redirect,
    input  logic [WIDTH-1:0]           RedirectPC,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_instr,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_pcplus4,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int unsigned      CW         = $clog2(DEPTH + 1);
    localparam int unsigned      AW         = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INSTR_BYTES - 1);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;

    logic [WIDTH-1:0] q_instr [DEPTH];
    logic [WIDTH-1:0] q_pc    [DEPTH];

    logic [CW:0]      credits;
    logic             issue;
    logic             push;
    logic             pop;

    // Handshake and issue decisions; an outstanding request already owns a queue slot.
    always_comb begin
        credits   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue     = !Reset && !Redirect && (credits < (CW + 1)'(DEPTH));
        push      = inflight_q && !Redirect && !Reset;
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready && !Redirect && !Reset;
        imem_req  = issue;
        imem_addr = fetch_pc_q;
    end

    // Next-state for fetch PC, in-flight tracking and queue pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;

        if (Redirect) begin
            fetch_pc_d = RedirectPC & ALIGN_MASK;
            inflight_d = 1'b0;
            count_d    = '0;
            rptr_d     = '0;
            wptr_d     = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + STEP;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
        end
    end

    // Queue storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wptr_q] <= imem_rdata;
            q_pc[wptr_q]    <= inflight_pc_q;
        end
    end

    // Head view; PC+INSTR_BYTES is derived from the stored PC rather than kept per entry.
    always_comb begin
        out_instr   = q_instr[rptr_q];
        out_pc      = q_pc[rptr_q];
        out_pcplus4 = q_pc[rptr_q] + STEP;
        Count       = count_q;
    end

endmodule
